// File: rtl/instr_sequencer.sv
// Hack-style fetch/decode/execute sequencer: owns PC and IR, drives the ALU controls and the _memory write strobes.
// Every instruction takes three cycles (FETCH, DECODE, EXEC); strobes and the PC update happen only in EXEC.
module instr_sequencer #(
   parameter int PC_W = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   output logic [PC_W-1:0] rom_addr,
   input  logic [15:0]     rom_data,
   input  logic [15:0]     a_in,
   input  logic [15:0]     alu_out,
   input  logic            alu_zr,
   input  logic            alu_ng,
   output logic            alu_a_sel,
   output logic [5:0]      alu_ctrl,
   output logic [15:0]     din,
   output logic            storeA,
   output logic            storeD,
   output logic            store_ram,
   output logic [PC_W-1:0] pc
);

   typedef enum logic [1:0] {FETCH, DECODE, EXEC} state_t;

   state_t          state_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [15:0]     ir_q;
   logic            is_c;
   logic            exec;
   logic            jmp;

   assign exec = (state_q == EXEC);
   assign is_c = ir_q[15];

   // Jump target is the pre-edge A value; a simultaneous A write lands after this edge.
   assign jmp  = is_c & ((ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr));
   assign pc_d = jmp ? a_in[PC_W-1:0] : pc_q + PC_W'(1);

   if (PC_W < 16) begin : g_unused_a
      logic unused_a_hi;
      assign unused_a_hi = ^a_in[15:PC_W];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         case (state_q)
            FETCH: begin
               if (run) state_q <= DECODE;
            end
            DECODE: begin
               ir_q    <= rom_data;
               state_q <= EXEC;
            end
            EXEC: begin
               pc_q    <= pc_d;
               state_q <= FETCH;
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   // Strobes decode from the live state so an asynchronous reset kills them immediately.
   always_comb begin
      din       = is_c ? alu_out : {1'b0, ir_q[14:0]};
      storeA    = exec & (~is_c | ir_q[5]);
      storeD    = exec & is_c & ir_q[4];
      store_ram = exec & is_c & ir_q[3];
   end

   assign rom_addr  = pc_q;
   assign pc        = pc_q;
   assign alu_a_sel = ir_q[12];
   assign alu_ctrl  = ir_q[11:6];

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: synchronous ROM, Hack ALU and _memory models around the DUT,
// with an ISA-level reference that queues the expected per-cycle outputs of each program.
module tb_instr_sequencer;

   localparam int PC_W = 15;

   logic            clk = 1'b0;
   logic            reset;
   logic            run;
   logic            mem_clr;
   logic [PC_W-1:0] rom_addr;
   logic [PC_W-1:0] pc;
   logic [15:0]     rom_data;
   logic [15:0]     a_in;
   logic [15:0]     alu_out;
   logic            alu_zr;
   logic            alu_ng;
   logic            alu_a_sel;
   logic [5:0]      alu_ctrl;
   logic [15:0]     din;
   logic            storeA;
   logic            storeD;
   logic            store_ram;

   logic [15:0] rom [0:32767];
   logic [15:0] ram [0:65535];
   logic [15:0] a_m;
   logic [15:0] d_m;
   logic [15:0] m_val;

   logic [15:0] gram [0:65535];
   logic [15:0] g_a;
   logic [15:0] g_d;
   logic [15:0] touched[$];

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [2:0]      st;
      logic [15:0]     din;
      logic [6:0]      ctrl;
      logic            exec;
   } exp_t;

   exp_t sbq[$];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   instr_sequencer #(.PC_W(PC_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .a_in      (a_in),
      .alu_out   (alu_out),
      .alu_zr    (alu_zr),
      .alu_ng    (alu_ng),
      .alu_a_sel (alu_a_sel),
      .alu_ctrl  (alu_ctrl),
      .din       (din),
      .storeA    (storeA),
      .storeD    (storeD),
      .store_ram (store_ram),
      .pc        (pc)
   );

   function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
      logic [15:0] xx;
      logic [15:0] yy;
      logic [15:0] o;
      xx = c[5] ? 16'h0 : x;
      xx = c[4] ? ~xx : xx;
      yy = c[3] ? 16'h0 : y;
      yy = c[2] ? ~yy : yy;
      o  = c[1] ? (xx + yy) : (xx & yy);
      o  = c[0] ? ~o : o;
      return o;
   endfunction

   // Environment: synchronous ROM, ALU and the A/D/RAM of _memory.
   always @(posedge clk) rom_data <= rom[rom_addr];

   assign m_val   = ram[a_m];
   assign a_in    = a_m;
   assign alu_out = alu_f(d_m, alu_a_sel ? m_val : a_m, alu_ctrl);
   assign alu_zr  = (alu_out == 16'h0);
   assign alu_ng  = alu_out[15];

   always @(posedge clk) begin
      if (mem_clr) begin
         a_m <= 16'h0;
         d_m <= 16'h0;
         for (int i = 0; i < 65536; i++) ram[i] <= 16'h0;
      end else begin
         if (store_ram) ram[a_m] <= din;
         if (storeA)    a_m      <= din;
         if (storeD)    d_m      <= din;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic rom_clear();
      for (int i = 0; i < 32768; i++) rom[i] = 16'h0;
   endtask

   // Holds reset across one edge (clearing the memory model), releases at a negedge,
   // and leaves the bench 1 time unit into cycle 1.
   task automatic start(input logic r);
      reset   = 1'b1;
      run     = 1'b0;
      mem_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_clr = 1'b0;
      reset   = 1'b0;
      run     = r;
      g_a     = 16'h0;
      g_d     = 16'h0;
      touched.delete();
      for (int i = 0; i < 65536; i++) gram[i] = 16'h0;
      #1;
   endtask

   // ISA-level reference: three cycles per instruction, strobes and din only in EXEC.
   task automatic build_exp(input int n);
      logic [PC_W-1:0] p;
      p = '0;
      for (int i = 0; i < n; i++) begin
         logic [15:0]     ir;
         logic [15:0]     y;
         logic [15:0]     o;
         logic            zr;
         logic            ng;
         logic            j;
         logic [PC_W-1:0] np;
         exp_t            e;
         ir     = rom[p];
         e.pc   = p;
         e.st   = 3'b000;
         e.din  = 16'h0;
         e.ctrl = 7'h0;
         e.exec = 1'b0;
         sbq.push_back(e);
         sbq.push_back(e);
         e.exec = 1'b1;
         e.ctrl = ir[12:6];
         if (!ir[15]) begin
            e.din = {1'b0, ir[14:0]};
            e.st  = 3'b100;
            g_a   = e.din;
            np    = p + 15'd1;
         end else begin
            y  = ir[12] ? gram[g_a] : g_a;
            o  = alu_f(g_d, y, ir[11:6]);
            zr = (o == 16'h0);
            ng = o[15];
            j  = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
            np = j ? g_a[PC_W-1:0] : p + 15'd1;
            e.din = o;
            e.st  = ir[5:3];
            if (ir[3]) begin
               gram[g_a] = o;
               touched.push_back(g_a);
            end
            if (ir[5]) g_a = o;
            if (ir[4]) g_d = o;
         end
         sbq.push_back(e);
         p = np;
      end
      begin
         exp_t f;
         f.pc   = p;
         f.st   = 3'b000;
         f.din  = 16'h0;
         f.ctrl = 7'h0;
         f.exec = 1'b0;
         sbq.push_back(f);
      end
   endtask

   task automatic run_prog(input string name, input int n);
      build_exp(n);
      while (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk({name, ".pc"}, 32'(pc), 32'(e.pc));
         chk({name, ".rom_addr"}, 32'(rom_addr), 32'(e.pc));
         chk({name, ".strobes"}, 32'({storeA, storeD, store_ram}), 32'(e.st));
         if (e.exec) begin
            chk({name, ".din"}, 32'(din), 32'(e.din));
            chk({name, ".alu_ctl"}, 32'({alu_a_sel, alu_ctrl}), 32'(e.ctrl));
         end
         if (sbq.size() > 0) begin
            @(negedge clk);
            #1;
         end
      end
      chk({name, ".A"}, 32'(a_m), 32'(g_a));
      chk({name, ".D"}, 32'(d_m), 32'(g_d));
      foreach (touched[k]) chk({name, ".RAM"}, 32'(ram[touched[k]]), 32'(gram[touched[k]]));
   endtask

   initial begin
      reset   = 1'b0;
      run     = 1'b0;
      mem_clr = 1'b0;
      rom_clear();
      #2 reset = 1'b1;
      #1;
      chk("rst.pc", 32'(pc), 32'h0);
      chk("rst.rom_addr", 32'(rom_addr), 32'h0);
      chk("rst.strobes", 32'({storeA, storeD, store_ram}), 32'h0);
      chk("rst.alu_ctl", 32'({alu_a_sel, alu_ctrl}), 32'h0);
      chk("rst.din", 32'(din), 32'h0);

      // Idle with run low: parked in FETCH.
      rom[0] = 16'h0005;
      start(1'b0);
      for (int c = 1; c <= 5; c++) begin
         chk("idle.pc", 32'(pc), 32'h0);
         chk("idle.strobes", 32'({storeA, storeD, store_ram}), 32'h0);
         @(negedge clk);
         #1;
      end

      // @5; D=A; M=D
      rom_clear();
      rom[0] = 16'h0005;
      rom[1] = 16'hEC10;
      rom[2] = 16'hE308;
      start(1'b1);
      run_prog("amd", 3);

      // @7; 0;JMP -> fetch from 7
      rom_clear();
      rom[0] = 16'h0007;
      rom[1] = 16'hEA87;
      rom[7] = 16'h0003;
      start(1'b1);
      run_prog("jmp", 3);

      // D=-1; @9; D;JGT (no jump), @3; D=A; @9; D;JGT (jump), AMD=M+1
      rom_clear();
      rom[0] = 16'hEE90;
      rom[1] = 16'h0009;
      rom[2] = 16'hE301;
      rom[3] = 16'h0003;
      rom[4] = 16'hEC10;
      rom[5] = 16'h0009;
      rom[6] = 16'hE301;
      rom[9] = 16'hFDF8;
      start(1'b1);
      run_prog("jgt", 8);

      // A=-1; 0;JMP drops bit 15 -> 0x7FFF; @1 at 0x7FFF wraps pc to 0
      rom_clear();
      rom[0]     = 16'hEEA0;
      rom[1]     = 16'hEA87;
      rom[32767] = 16'h0001;
      start(1'b1);
      run_prog("wrap", 3);

      // Random program over the full ROM.
      for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom);
      start(1'b1);
      run_prog("rand", 40);

      // run dropped during DECODE: the instruction still completes, then parks.
      rom_clear();
      rom[0] = 16'h0005;
      start(1'b1);
      chk("rdrop.pc", 32'(pc), 32'h0);
      @(posedge clk);
      #1 run = 1'b0;
      for (int c = 2; c <= 8; c++) begin
         @(negedge clk);
         #1;
         chk("rdrop.strobes", 32'({storeA, storeD, store_ram}), (c == 3) ? 32'h4 : 32'h0);
         chk("rdrop.pc", 32'(pc), (c > 3) ? 32'h1 : 32'h0);
      end
      chk("rdrop.A", 32'(a_m), 32'h5);

      // Asynchronous reset in the EXEC cycle of D=A.
      rom_clear();
      rom[0] = 16'h0005;
      rom[1] = 16'hEC10;
      start(1'b1);
      repeat (5) begin
         @(negedge clk);
         #1;
      end
      chk("arst.sD_before", 32'(storeD), 32'h1);
      reset = 1'b1;
      #1;
      chk("arst.strobes", 32'({storeA, storeD, store_ram}), 32'h0);
      chk("arst.pc", 32'(pc), 32'h0);
      @(posedge clk);
      #1;
      chk("arst.D", 32'(d_m), 32'h0);
      chk("arst.A", 32'(a_m), 32'h5);
      chk("arst.pc_after", 32'(pc), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
